// File: rtl/trs80_cas_pkg.sv
// trs80_cas_pkg: shared state encoding and default timing constants for cassette playback
package trs80_cas_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, PLAY, STALL, DONE} cas_state_t;
  localparam int CAS_BIT_TICKS   = 3548;
  localparam int CAS_PULSE_TICKS = 128;
  localparam int CAS_DATA_OFS    = 1774;
endpackage

// File: rtl/cas_cell_timer.sv
// cas_cell_timer: bit-cell tick counter; windows reflect the count after the current cycle
module cas_cell_timer #(
  parameter int BIT_TICKS   = trs80_cas_pkg::CAS_BIT_TICKS,
  parameter int PULSE_TICKS = trs80_cas_pkg::CAS_PULSE_TICKS,
  parameter int DATA_OFS    = trs80_cas_pkg::CAS_DATA_OFS
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce,
  input  logic run,
  input  logic clear,
  output logic clk_win,
  output logic data_win,
  output logic cell_end
);
  localparam logic [11:0] LAST = 12'(BIT_TICKS - 1);
  localparam logic [11:0] PW   = 12'(PULSE_TICKS);
  localparam logic [11:0] D0   = 12'(DATA_OFS);
  localparam logic [11:0] D1   = 12'(DATA_OFS + PULSE_TICKS);
  logic [11:0] cnt, cnt_n;
  assign cell_end = ce && run && cnt == LAST;
  assign cnt_n    = clear ? '0 : (ce && run) ? (cell_end ? '0 : cnt + 12'd1) : cnt;
  // windows use the next count so the registered cas_in lines up with the tick
  assign clk_win  = cnt_n < PW;
  assign data_win = cnt_n >= D0 && cnt_n < D1;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= cnt_n;
endmodule

// File: rtl/cas_player.sv
// cas_player: plays a .CAS image from cassette RAM as Level II 500-baud pulses
// with a one-byte prefetch so consecutive bytes stream without gaps
module cas_player
  import trs80_cas_pkg::*;
#(
  parameter int BIT_TICKS   = CAS_BIT_TICKS,
  parameter int PULSE_TICKS = CAS_PULSE_TICKS,
  parameter int DATA_OFS    = CAS_DATA_OFS
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        motor,
  input  logic        cas_loaded,
  input  logic [15:0] cas_len,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data,
  output logic        cas_in,
  output logic        busy,
  output logic        done,
  output logic        underrun
);
  cas_state_t state;
  logic [7:0] sh, pbuf;
  logic [2:0] bidx;
  logic [15:0] cur;
  logic pfull, loaded_q, clk_win, data_win, cell_end, rise, fall, ack, more;
  assign rise     = cas_loaded & ~loaded_q;
  assign fall     = ~cas_loaded & loaded_q;
  assign ack      = rd_req & rd_ack;
  assign more     = {1'b0, cur} + 17'd1 < {1'b0, cas_len};
  assign busy     = state == FETCH || state == PLAY || state == STALL;
  assign done     = state == DONE;
  cas_cell_timer #(.BIT_TICKS(BIT_TICKS), .PULSE_TICKS(PULSE_TICKS), .DATA_OFS(DATA_OFS)) u_timer (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce),
    .run(motor && state == PLAY), .clear(state != PLAY),
    .clk_win(clk_win), .data_win(data_win), .cell_end(cell_end)
  );
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      sh       <= '0;
      pbuf     <= '0;
      bidx     <= '0;
      cur      <= '0;
      pfull    <= 1'b0;
      loaded_q <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      cas_in   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      loaded_q <= cas_loaded;
      cas_in   <= 1'b0;
      if (rise || fall) begin
        state  <= IDLE;
        rd_req <= 1'b0;
        pfull  <= 1'b0;
        if (rise) begin
          cur      <= '0;
          rd_addr  <= '0;
          underrun <= 1'b0;
        end
      end else case (state)
        IDLE:
          if (cas_len == 16'd0) state <= DONE;
          else if (cas_loaded && motor) begin
            state   <= FETCH;
            cur     <= '0;
            rd_addr <= '0;
            rd_req  <= 1'b1;
          end
        FETCH, STALL:
          if (ack) begin
            sh     <= rd_data;
            bidx   <= 3'd7;
            rd_req <= 1'b0;
            state  <= PLAY;
            cas_in <= motor;
            if (state == STALL) cur <= cur + 16'd1;
          end
        PLAY: begin
          cas_in <= motor && (clk_win || (data_win && sh[7]));
          if (ack && !(cell_end && bidx == 3'd0)) begin
            pbuf   <= rd_data;
            pfull  <= 1'b1;
            rd_req <= 1'b0;
          end else if (bidx == 3'd7 && !rd_req && !pfull && more) begin
            rd_req  <= 1'b1;
            rd_addr <= cur + 16'd1;
          end
          if (cell_end) begin
            if (bidx != 3'd0) begin
              sh   <= {sh[6:0], 1'b0};
              bidx <= bidx - 3'd1;
            end else if (pfull) begin
              sh    <= pbuf;
              pfull <= 1'b0;
              bidx  <= 3'd7;
              cur   <= cur + 16'd1;
            end else if (ack) begin
              sh     <= rd_data;
              rd_req <= 1'b0;
              bidx   <= 3'd7;
              cur    <= cur + 16'd1;
            end else begin
              cas_in   <= 1'b0;
              state    <= rd_req ? STALL : DONE;
              underrun <= underrun | rd_req;
            end
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: directed checks of cas_player with scaled cell timing (40/6/20 ticks)
module tb_cas_player;
  localparam logic [39:0] CLKP = 40'h00_0000_003F;
  localparam logic [39:0] DATP = 40'h00_03F0_0000;
  logic clk = 1'b0, reset_n, ce, motor, cas_loaded;
  logic [15:0] cas_len, rd_addr;
  logic rd_req, rd_ack = 1'b0, cas_in, busy, done, underrun;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] mem [4];
  int lat_tbl [4];
  int wait_cnt = 0;
  int tests = 0, fails = 0;
  int hi, pre, post;
  logic seen;

  cas_player #(.BIT_TICKS(40), .PULSE_TICKS(6), .DATA_OFS(20)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .motor(motor), .cas_loaded(cas_loaded),
    .cas_len(cas_len), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .cas_in(cas_in), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rd_ack = 1'b0;
    if (!rd_req) wait_cnt = 0;
    else if (wait_cnt >= lat_tbl[rd_addr[1:0]]) begin
      rd_ack   = 1'b1;
      rd_data  = mem[rd_addr[1:0]];
      wait_cnt = 0;
    end else wait_cnt++;
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rewind(input string tag);
    cas_loaded = 1'b0;
    tick(1);
    cas_loaded = 1'b1;
    tick(1);
    check({tag, " rew done"}, 40'(done), 40'd0);
    check({tag, " rew underrun"}, 40'(underrun), 40'd0);
    check({tag, " rew addr"}, 40'(rd_addr), 40'd0);
    check({tag, " rew busy"}, 40'(busy), 40'd0);
  endtask

  task automatic wait_ack(input string tag, output int highs);
    logic f;
    f = 1'b0;
    highs = 0;
    for (int i = 0; i < 3000 && !f; i++) begin
      tick(1);
      if (rd_ack) f = 1'b1;
      else highs += int'(cas_in);
    end
    check({tag, " ack seen"}, 40'(f), 40'd1);
  endtask

  task automatic play_cells(input string tag, input logic [7:0] b);
    logic [39:0] obs;
    for (int c = 0; c < 8; c++) begin
      obs = '0;
      for (int k = 0; k < 40; k++) begin
        obs[k] = cas_in;
        tick(1);
      end
      check($sformatf("%s cell%0d", tag, c), obs, CLKP | (b[7-c] ? DATP : 40'd0));
    end
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; motor = 1'b1; cas_loaded = 1'b0; cas_len = 16'd1;
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    for (int i = 0; i < 4; i++) lat_tbl[i] = 1;
    tick(3);
    check("reset outs", 40'({cas_in, rd_req, busy, done, underrun}), 40'd0);
    check("reset addr", 40'(rd_addr), 40'd0);
    reset_n = 1'b1;
    // single byte 0xA5
    rewind("t1");
    wait_ack("t1", hi);
    check("t1 busy", 40'(busy), 40'd1);
    play_cells("t1", 8'hA5);
    check("t1 done", 40'(done), 40'd1);
    check("t1 quiet", 40'({cas_in, rd_req, busy, underrun}), 40'd0);
    // three bytes streamed through the prefetch buffer
    cas_len = 16'd3;
    mem[0] = 8'h3C; mem[1] = 8'h81; mem[2] = 8'hFF;
    for (int i = 0; i < 4; i++) lat_tbl[i] = 100;
    rewind("t2");
    wait_ack("t2", hi);
    play_cells("t2 b0", 8'h3C);
    play_cells("t2 b1", 8'h81);
    play_cells("t2 b2", 8'hFF);
    check("t2 done", 40'(done), 40'd1);
    check("t2 underrun", 40'(underrun), 40'd0);
    // late second byte forces a stall
    cas_len = 16'd2;
    mem[0] = 8'h80; mem[1] = 8'h01;
    lat_tbl[0] = 1; lat_tbl[1] = 600;
    rewind("t3");
    wait_ack("t3", hi);
    play_cells("t3 b0", 8'h80);
    check("t3 underrun", 40'(underrun), 40'd1);
    check("t3 stall outs", 40'({cas_in, busy, done, rd_req}), 40'b0101);
    check("t3 stall addr", 40'(rd_addr), 40'd1);
    wait_ack("t3 stall", hi);
    check("t3 stall highs", 40'(hi), 40'd0);
    play_cells("t3 b1", 8'h01);
    check("t3 done", 40'(done), 40'd1);
    check("t3 sticky", 40'(underrun), 40'd1);
    // motor drop in the middle of a clock pulse
    cas_len = 16'd1;
    mem[0] = 8'h00; lat_tbl[0] = 1;
    rewind("t4");
    wait_ack("t4", hi);
    pre = int'(cas_in);
    tick(1);
    pre += int'(cas_in);
    tick(1);
    pre += int'(cas_in);
    motor = 1'b0;
    hi = 0;
    repeat (25) begin
      tick(1);
      hi += int'(cas_in);
    end
    check("t4 drop busy", 40'(busy), 40'd1);
    motor = 1'b1;
    post = 0;
    repeat (10) begin
      tick(1);
      post += int'(cas_in);
    end
    check("t4 pre highs", 40'(pre), 40'd3);
    check("t4 drop highs", 40'(hi), 40'd0);
    check("t4 post highs", 40'(post), 40'd3);
    // rewind mid-byte with a prefetch outstanding, then async reset mid-cell
    cas_len = 16'd2;
    mem[0] = 8'hFF; lat_tbl[0] = 1; lat_tbl[1] = 1000;
    rewind("t5a");
    wait_ack("t5a", hi);
    tick(50);
    check("t5 pf req", 40'(rd_req), 40'd1);
    check("t5 pf addr", 40'(rd_addr), 40'd1);
    rewind("t5b");
    wait_ack("t5b", hi);
    check("t5 refetch busy", 40'(busy), 40'd1);
    tick(10);
    reset_n = 1'b0;
    #1;
    check("t5 reset outs", 40'({cas_in, rd_req, busy, done, underrun}), 40'd0);
    check("t5 reset addr", 40'(rd_addr), 40'd0);
    tick(2);
    // empty image goes straight to DONE
    cas_len = 16'd0;
    cas_loaded = 1'b0;
    reset_n = 1'b1;
    seen = 1'b0;
    hi = 0;
    repeat (30) begin
      tick(1);
      seen |= rd_req;
      hi += int'(cas_in);
    end
    check("t6 no req", 40'(seen), 40'd0);
    check("t6 no pulse", 40'(hi), 40'd0);
    check("t6 done", 40'(done), 40'd1);
    check("t6 busy", 40'(busy), 40'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
